// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU's SRAM-like instruction and data ports onto one AXI3 master.
// At most one read and one write are outstanding, and every burst is a single beat.
module cpu_axi_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_AR = 2'd1, RD_R = 2'd2} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_AW_W = 2'd1, WR_B = 2'd2} wr_state_t;

  rd_state_t   rd_state_r, rd_state_nxt;
  wr_state_t   wr_state_r, wr_state_nxt;
  logic        rd_id_r;
  logic [31:0] araddr_r, awaddr_r, wdata_r;
  logic [2:0]  arsize_r, awsize_r;
  logic [3:0]  wstrb_r;
  logic        arvalid_r, awvalid_r, wvalid_r;
  logic        data_busy, data_rd_acc, data_wr_acc, inst_acc;
  logic        r_done;

  // The data port stays blocked while any data read or write is in flight (keeps RAW order).
  assign data_busy   = ((rd_state_r != RD_IDLE) && rd_id_r) || (wr_state_r != WR_IDLE);
  assign data_rd_acc = (rd_state_r == RD_IDLE) && data_req && !data_wr && !data_busy;
  assign data_wr_acc = (wr_state_r == WR_IDLE) && data_req && data_wr && !data_busy;
  assign inst_acc    = (rd_state_r == RD_IDLE) && inst_req && !data_rd_acc;
  assign r_done      = (rd_state_r == RD_R) && rvalid;

  assign inst_addr_ok = inst_acc;
  assign data_addr_ok = data_rd_acc || data_wr_acc;
  assign inst_data_ok = r_done && !rd_id_r;
  assign data_data_ok = (r_done && rd_id_r) || ((wr_state_r == WR_B) && bvalid);
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid    = {3'd0, rd_id_r};
  assign araddr  = araddr_r;
  assign arsize  = arsize_r;
  assign arvalid = arvalid_r;
  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign rready  = (rd_state_r == RD_R);

  assign awid    = 4'd1;
  assign awaddr  = awaddr_r;
  assign awsize  = awsize_r;
  assign awvalid = awvalid_r;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = 4'd1;
  assign wdata   = wdata_r;
  assign wstrb   = wstrb_r;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_r;
  assign bready  = (wr_state_r == WR_B);

  logic unused;
  assign unused = ^{inst_wr, inst_wstrb, inst_wdata, rid, rresp, rlast, bid, bresp};

  // Read FSM next state.
  always_comb begin
    rd_state_nxt = rd_state_r;
    case (rd_state_r)
      RD_IDLE: if (data_rd_acc || inst_acc) rd_state_nxt = RD_AR; else rd_state_nxt = RD_IDLE;
      RD_AR:   if (arready) rd_state_nxt = RD_R; else rd_state_nxt = RD_AR;
      RD_R:    if (rvalid) rd_state_nxt = RD_IDLE; else rd_state_nxt = RD_R;
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  // Write FSM next state; AW and W may finish in either order or together.
  always_comb begin
    wr_state_nxt = wr_state_r;
    case (wr_state_r)
      WR_IDLE: if (data_wr_acc) wr_state_nxt = WR_AW_W; else wr_state_nxt = WR_IDLE;
      WR_AW_W: if ((!awvalid_r || awready) && (!wvalid_r || wready)) wr_state_nxt = WR_B;
               else wr_state_nxt = WR_AW_W;
      WR_B:    if (bvalid) wr_state_nxt = WR_IDLE; else wr_state_nxt = WR_B;
      default: wr_state_nxt = WR_IDLE;
    endcase
  end

  // Read-side state, request latch and AR valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_r <= RD_IDLE;
      rd_id_r    <= 1'b0;
      araddr_r   <= 32'd0;
      arsize_r   <= 3'd0;
      arvalid_r  <= 1'b0;
    end else begin
      rd_state_r <= rd_state_nxt;
      if (data_rd_acc) begin
        rd_id_r   <= 1'b1;
        araddr_r  <= data_addr;
        arsize_r  <= {1'b0, data_size};
        arvalid_r <= 1'b1;
      end else if (inst_acc) begin
        rd_id_r   <= 1'b0;
        araddr_r  <= inst_addr;
        arsize_r  <= {1'b0, inst_size};
        arvalid_r <= 1'b1;
      end else if (arvalid_r && arready) begin
        arvalid_r <= 1'b0;
      end
    end
  end

  // Write-side state, request latch and independent AW/W valids.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_r <= WR_IDLE;
      awaddr_r   <= 32'd0;
      awsize_r   <= 3'd0;
      wdata_r    <= 32'd0;
      wstrb_r    <= 4'd0;
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
    end else begin
      wr_state_r <= wr_state_nxt;
      if (data_wr_acc) begin
        awaddr_r  <= data_addr;
        awsize_r  <= {1'b0, data_size};
        wdata_r   <= data_wdata;
        wstrb_r   <= data_wstrb;
        awvalid_r <= 1'b1;
        wvalid_r  <= 1'b1;
      end else begin
        if (awvalid_r && awready) awvalid_r <= 1'b0;
        if (wvalid_r && wready) wvalid_r <= 1'b0;
      end
    end
  end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Converts the CPU core's two SRAM-like ports (instruction fetch, data access) into a single AXI3 master. It sits directly downstream of the CPU top, replacing the direct inst/data SRAM connections, and provides req/addr_ok/data_ok handshakes so IF and MEM can stall on memory latency. It supports at most one outstanding AXI read and one outstanding AXI write, and uses fixed single-beat bursts.

## Interface
- No parameters. AXI fields are fixed: `arlen`/`awlen`=0, `arburst`/`awburst`=2'b01, lock/cache/prot=0, `awid`=`wid`=4'd1, `wlast`=1.
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high.
- `inst_req`, `inst_wr`, `inst_size[1:0]`, `inst_addr[31:0]`, `inst_wstrb[3:0]`, `inst_wdata[31:0]`  in  SRAM-like instruction request. `inst_wr` must be 0.
- `inst_addr_ok`  out  1  request accepted this cycle.
- `inst_data_ok`  out  1  read data valid this cycle.
- `inst_rdata`  out  32  read data.
- `data_req`, `data_wr`, `data_size[1:0]`, `data_addr[31:0]`, `data_wstrb[3:0]`, `data_wdata[31:0]`  in  SRAM-like data request.
- `data_addr_ok`, `data_data_ok`  out  1 each  same meaning as the instruction-side signals.
- `data_rdata`  out  32  read data.
- AR channel: `arid[3:0]`, `araddr[31:0]`, `arsize[2:0]`, `arvalid` out; `arready` in.
- R channel: `rid[3:0]`, `rdata[31:0]`, `rresp[1:0]`, `rlast`, `rvalid` in; `rready` out.
- AW channel: `awaddr[31:0]`, `awsize[2:0]`, `awvalid` out; `awready` in.
- W channel: `wdata[31:0]`, `wstrb[3:0]`, `wvalid` out; `wready` in.
- B channel: `bid[3:0]`, `bresp[1:0]`, `bvalid` in; `bready` out.

## Operation
- **Read FSM states:** RD_IDLE, RD_AR, RD_R.
  - In RD_IDLE, select a read requester. A data read (`data_req & ~data_wr`) has priority over an instruction read.
  - Accept the selected request: pulse its `addr_ok`, latch addr/size/id (id 0 = inst, 1 = data), then go to RD_AR.
  - In RD_AR, assert `arvalid`. `arsize` = {1'b0, size}. On `arvalid & arready`, go to RD_R.
  - In RD_R, assert `rready`. On `rvalid`, return to RD_IDLE.
  - On the R handshake, pulse `data_ok` of the port indicated by the latched id (not `rid`), with `*_rdata` = `rdata` combinationally in the same cycle.
- **Write FSM states:** WR_IDLE, WR_AW_W, WR_B.
  - In WR_IDLE, accept `data_req & data_wr`: pulse `data_addr_ok` and latch addr/size/wstrb/wdata. Set `awvalid` and `wvalid`.
  - In WR_AW_W, each valid drops independently on its own handshake. AW and W may complete in the same cycle or in either order. When both have completed, go to WR_B.
  - In WR_B, assert `bready`. On `bvalid`, pulse `data_data_ok` and return to WR_IDLE.
- **Data-port ordering:** the data port never has more than one outstanding transaction.
  - `data_addr_ok` is gated 0 while any data read is in RD_AR/RD_R or any write is in WR_AW_W/WR_B.
  - This rule also guarantees read-after-write ordering.
- **Instruction-port ordering:** the instruction port has at most one outstanding read, enforced by the read FSM.
  - Instruction reads may overlap a data write.
- **Same-cycle requests:** if both a data read and a data write are presented in one cycle, that is illegal (one `data_req` carries one `data_wr`) and needs no handling.
- **Responses:** `rresp` and `bresp` are ignored. The bridge never generates errors.

## Timing
- **Reset values:** all FSMs go to IDLE. `arvalid`, `awvalid`, `wvalid`, `rready`, `bready`, `*_addr_ok`, `*_data_ok` = 0. `araddr`, `awaddr`, `wdata`, `wstrb`, `arid` = 0.
  - Reset asserted mid-transaction abandons it without waiting for AXI completion. The slave is reset simultaneously.
- **`addr_ok`:** combinational from req and FSM state. It is asserted in the same cycle as req (cycle 0).
- **`arvalid`/`awvalid`/`wvalid`:** registered, high from cycle 1. They stay high and stable until their handshake completes.
- **Minimum read latency:** `addr_ok` in cycle 0, AR handshake in cycle 1, R handshake (`data_ok`) in cycle 2.
- **Minimum write latency:** `addr_ok` in cycle 0, AW and W handshakes in cycle 1, `bvalid` (`data_ok`) in cycle 2.
- **Back-to-back requests:** a new request can be accepted in the cycle after the FSM returns to IDLE. It cannot be accepted in the same cycle as `data_ok`.
- **`data_ok`:** a single-cycle pulse per transaction. `rready` and `bready` are high only in RD_R and WR_B respectively.

## Test plan
- **Instruction read:** `inst_req`=1, addr=0x1C000000, size=2; slave returns rdata=0x02800C0C after 3 wait cycles. Required: `inst_addr_ok` in cycle 0; `araddr`=0x1C000000, `arid`=0, `arsize`=3'b010; `inst_data_ok`=1 for exactly one cycle with `inst_rdata`=0x02800C0C.
- **Read arbitration:** inst and data reads presented in the same cycle. Required: only `data_addr_ok` is asserted and `arid`=1. The inst read is accepted in the cycle after the data read's R handshake.
- **Write, AW before W:** `data_req`, `wr`=1, addr=0x1C008000, wstrb=4'b0011, wdata=0x0000BEEF. `awready` in cycle 1, `wready` in cycle 3. Required: `awvalid` drops after cycle 1, `wvalid` held until cycle 3, `bready` from cycle 4. `data_data_ok` pulses on `bvalid`.
- **Write, W before AW:** the same write with `wready` in cycle 1 and `awready` in cycle 2. Required: behaviour mirrors the previous scenario.
- **RAW blocking:** a data write whose B response is delayed 5 cycles, followed by a data read to the same address. Required: `data_addr_ok`=0 until the cycle after `data_data_ok` of the write. Meanwhile an inst read issued in that window completes normally.
- **Reset mid-read:** reset asserted while in RD_R with `rvalid`=0. Required: next cycle all outputs are at their reset values and no `data_ok` is ever produced for the abandoned read.
